wb_slave_mem_responder: RTL and testbench
=========================================

# wb_slave_mem_responder

Synthesizable Wishbone B3 classic slave that models system memory for the Ethernet MAC's DMA master port (m_wb_*), serving buffer-descriptor data fetches and received-frame writes. It sits in the testbench environment opposite the MAC master interface and completes the protocol loop that the host-side master driver starts on the MAC slave port. The block provides configurable wait states, byte-lane writes, address-window checking with error termination, and access statistics for the scoreboard.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of word 0 of the memory window
- DEPTH_WORDS, 1024, number of 32-bit words (power of two, 16..65536)
- WAIT_STATES, 0, idle cycles inserted before ack/err (0..15)
- wb_clk_i  in  1  Wishbone clock; all logic is on the rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_adr_i  in  32  byte address from the MAC master
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables; bit n maps to dat[8n+7:8n]
- wb_we_i  in  1  1 = write, 0 = read
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data, valid while wb_ack_o is high
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination
- acc_cnt_o  out  16  count of completed accesses (ack or err), wraps
- err_cnt_o  out  8  count of err terminations, saturates at 8'hFF

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: when cyc&stb is high at an edge, latch adr/we/sel/dat. Go to WAIT if WAIT_STATES>0 (load wait counter = WAIT_STATES-1), otherwise go to RESP.
- WAIT: the counter decrements each cycle. At 0, go to RESP. If cyc or stb drops, return to IDLE with no termination and no memory change (abort).
- RESP: wb_ack_o or wb_err_o is high for exactly one cycle, then the FSM unconditionally returns to IDLE.
- Address check: in-window means BASE_ADDR ≤ adr < BASE_ADDR+4*DEPTH_WORDS and adr[1:0]==0.
  - Word index = (adr-BASE_ADDR)>>2, width $clog2(DEPTH_WORDS).
  - Out-of-window or misaligned accesses terminate with err, make no write, and return wb_dat_o=0.
- Writes: each byte with its sel bit set is written on the edge that enters RESP. A write with sel=0 is acked and changes nothing.
- Reads: wb_dat_o is registered on the edge entering RESP and holds the full word regardless of sel. wb_dat_o=0 outside RESP.
- Counters update on the edge entering RESP.
- Memory contents are not reset. They power up undefined; the bench preloads through hierarchical access or writes.

## Timing
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, acc_cnt_o=0, err_cnt_o=0, FSM=IDLE, wait counter=0.
- Latency: strobe sampled at edge N, termination high during cycle N+1+WAIT_STATES.
- The minimum spacing between terminations is 2 cycles, because RESP→IDLE is unconditional. A strobe still high during RESP is not re-sampled until IDLE, so it cannot produce a double ack.
- wb_ack_o and wb_err_o are never high together.
- Reset asserted mid-transfer: outputs clear immediately (asynchronous reset), the pending write is dropped, and memory is untouched.
- A simultaneous counter wrap (acc) and saturation (err) is handled independently.

## Configuration
- WB_RESP_ERR_INJECT_EN defined:
  - Adds input port err_inject_i (1 bit).
  - A high on err_inject_i at any edge arms a one-shot flag.
  - The next access entering RESP terminates with err (no write, dat_o=0), err_cnt_o increments, and the flag clears.
- Undefined: the port does not exist and only address errors produce err.

## Structure
- Shared package wishbone_package holds:
  - wb_resp_state_e (IDLE/WAIT/RESP)
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4
  - struct wb_resp_req_s (adr, dat, sel, we) used for the latched request
- Sub-module wb_resp_mem holds the byte-enable single-port RAM: DEPTH_WORDS x 32, 4 write enables, registered read. The top level holds the FSM, address check, counters and the injection logic.

## Test plan
- Reset: assert wb_rst_i mid-WAIT with WAIT_STATES=3 → ack/err/dat_o/counters read 0 at once; a later read of that address returns the prior value.
- Write 32'hDEADBEEF to BASE+0x10 with sel=4'hF, then read → ack 1 cycle after strobe (WAIT_STATES=0), dat_o=32'hDEADBEEF, acc_cnt_o=2.
- Byte lanes: write 32'h1122_3344 with sel=4'b0010 over 32'hFFFF_FFFF → read returns 32'hFFFF_33FF.
- Errors: read BASE+4*DEPTH_WORDS, then write BASE+0x2 → two err pulses, no ack, err_cnt_o=2, memory unchanged.
- Wait states and abort: WAIT_STATES=2 gives ack in the third cycle after strobe; dropping stb after 1 cycle gives no termination, no write, and acc_cnt_o unchanged.
- With WB_RESP_ERR_INJECT_EN: pulse err_inject_i, then write in-window 32'hA5A5A5A5 → err, location unchanged; the following access acks normally.

Source files
------------

// File: rtl/wishbone_package.sv
// rtl/wishbone_package.sv - shared Wishbone responder types and widths
//
// Purpose : bus widths, responder FSM state encoding and the latched
//           request record used by wb_slave_mem_responder.
// Contents: WB_ADR_W, WB_DAT_W, WB_SEL_W, wb_resp_state_e, wb_resp_req_s

package wishbone_package;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_resp_state_e;

    typedef struct packed {
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
        logic                we;
    } wb_resp_req_s;

endpackage

// File: rtl/wb_resp_mem.sv
// rtl/wb_resp_mem.sv - byte-enable single-port RAM with registered read
//
// Purpose : DEPTH_WORDS x 32 storage behind the Wishbone responder.
// Ports   : clk        - clock, rising edge
//           addr       - word index
//           we[3:0]    - per-byte write enables, bit n writes wdata[8n+7:8n]
//           re         - read enable, loads rdata on the next edge
//           wdata      - write data
//           rdata      - registered read data, holds until the next read
// Contents are deliberately not reset.

module wb_resp_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb_slave_mem_responder.sv
// rtl/wb_slave_mem_responder.sv - Wishbone B3 classic memory slave for the MAC DMA port
//
// Purpose : models system memory with programmable wait states, byte-lane
//           writes, address-window checking (err termination) and access
//           statistics.
// Ports   : wb_clk_i, wb_rst_i (async, active-high)
//           wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i - master request
//           wb_dat_o/wb_ack_o/wb_err_o                          - termination
//           acc_cnt_o - completed accesses (wraps)
//           err_cnt_o - err terminations (saturates at 8'hFF)
//           err_inject_i - only with WB_RESP_ERR_INJECT_EN: arms a one-shot
//                          forced err on the next access
// Macro   : WB_RESP_ERR_INJECT_EN

module wb_slave_mem_responder
    import wishbone_package::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [15:0] acc_cnt_o,
    output logic [7:0]  err_cnt_o
`ifdef WB_RESP_ERR_INJECT_EN
    ,
    input  logic        err_inject_i
`endif
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    // Window bounds carried in 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI    = WIN_LO + 33'(4 * DEPTH_WORDS);

    wb_resp_state_e state_q, state_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    wb_resp_req_s   req_q, req_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           rd_vld_q, rd_vld_d;
    logic [15:0]    acc_cnt_q, acc_cnt_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           inj_armed_q, inj_armed_d;

    wb_resp_req_s   req_live;
    wb_resp_req_s   req_eff;
    logic           strobe;
    logic           enter_resp;
    logic           in_window;
    logic           resp_err;
    logic [32:0]    adr_ext;
    logic [32:0]    adr_off;
    logic [AW-1:0]  word_idx;
    logic [3:0]     mem_we;
    logic [31:0]    mem_rdata;

    assign strobe   = wb_cyc_i & wb_stb_i;
    assign req_live = '{adr: wb_adr_i, dat: wb_dat_i, sel: wb_sel_i, we: wb_we_i};
    // With no wait states the access completes on the same edge that samples
    // the strobe, so the live bus request has to drive the memory directly.
    assign req_eff  = (state_q == IDLE) ? req_live : req_q;

    assign adr_ext   = {1'b0, req_eff.adr};
    assign adr_off   = adr_ext - WIN_LO;
    assign word_idx  = AW'(adr_off >> 2);
    assign in_window = (adr_ext >= WIN_LO) && (adr_ext < WIN_HI) &&
                       (req_eff.adr[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = req_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    req_d = req_live;
                    if (WAIT_STATES > 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A dropped strobe abandons the access without termination.
                if (!strobe) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Never re-sample here: a lingering strobe must not double-ack.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (enter_resp) begin
            state_d = RESP;
        end
    end

    always_comb begin
`ifdef WB_RESP_ERR_INJECT_EN
        resp_err    = !in_window || inj_armed_q;
        // Consumed by the access entering RESP; a pulse on that same edge re-arms.
        inj_armed_d = (enter_resp ? 1'b0 : inj_armed_q) | err_inject_i;
`else
        resp_err    = !in_window;
        inj_armed_d = 1'b0;
`endif
        ack_d     = enter_resp && !resp_err;
        err_d     = enter_resp && resp_err;
        rd_vld_d  = enter_resp && !resp_err && !req_eff.we;
        mem_we    = (enter_resp && !resp_err && req_eff.we && !wb_rst_i) ? req_eff.sel : 4'b0000;
        acc_cnt_d = acc_cnt_q + {15'd0, enter_resp};
        err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            req_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_vld_q    <= 1'b0;
            acc_cnt_q   <= 16'd0;
            err_cnt_q   <= 8'd0;
            inj_armed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_q       <= req_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rd_vld_q    <= rd_vld_d;
            acc_cnt_q   <= acc_cnt_d;
            err_cnt_q   <= err_cnt_d;
            inj_armed_q <= inj_armed_d;
        end
    end

    wb_resp_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk   (wb_clk_i),
        .addr  (word_idx),
        .we    (mem_we),
        .re    (rd_vld_d),
        .wdata (req_eff.dat),
        .rdata (mem_rdata)
    );

    // The RAM output register is not reset, so qualify it with a reset flop.
    assign wb_dat_o  = rd_vld_q ? mem_rdata : 32'h0;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign acc_cnt_o = acc_cnt_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_slave_mem_responder.sv
// tb/tb_wb_slave_mem_responder.sv - self-checking bench for wb_slave_mem_responder

module tb_wb_slave_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam int          NDUT  = 3;

    logic        clk;
    logic        rst   [NDUT];
    logic [31:0] adr   [NDUT];
    logic [31:0] dat_i [NDUT];
    logic [31:0] dat_o [NDUT];
    logic [3:0]  sel   [NDUT];
    logic        we    [NDUT];
    logic        cyc   [NDUT];
    logic        stb   [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];
    logic [15:0] acc   [NDUT];
    logic [7:0]  errc  [NDUT];
    logic        inj   [NDUT];

    wb_slave_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst[0]), .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]),
        .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
        .acc_cnt_o(acc[0]), .err_cnt_o(errc[0])
`ifdef WB_RESP_ERR_INJECT_EN
        , .err_inject_i(inj[0])
`endif
    );

    wb_slave_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst[1]), .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]),
        .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
        .acc_cnt_o(acc[1]), .err_cnt_o(errc[1])
`ifdef WB_RESP_ERR_INJECT_EN
        , .err_inject_i(inj[1])
`endif
    );

    wb_slave_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst[2]), .wb_adr_i(adr[2]), .wb_dat_i(dat_i[2]),
        .wb_sel_i(sel[2]), .wb_we_i(we[2]), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
        .wb_dat_o(dat_o[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]),
        .acc_cnt_o(acc[2]), .err_cnt_o(errc[2])
`ifdef WB_RESP_ERR_INJECT_EN
        , .err_inject_i(inj[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        x_err;
        logic        x_chk;
        logic [31:0] x_dat;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vt [20];
    int          n_checks;
    int          n_errors;
    logic [15:0] exp_acc  [NDUT];
    logic [7:0]  exp_errc [NDUT];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] s, input logic xe, input logic xc,
                                input logic [31:0] xd);
        vec_t v;
        v.we = w; v.adr = a; v.dat = wd; v.sel = s;
        v.x_err = xe; v.x_chk = xc; v.x_dat = xd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_counters(input int d, input string tag);
        chk({tag, "_acc_cnt"}, {16'h0, acc[d]}, {16'h0, exp_acc[d]});
        chk({tag, "_err_cnt"}, {24'h0, errc[d]}, {24'h0, exp_errc[d]});
    endtask

    // One full Wishbone access: expectation queued at drive time, popped
    // and compared when the DUT terminates (or the cycle budget runs out).
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic x_err, input logic x_chk,
                        input logic [31:0] x_dat, input string tag);
        exp_t e;
        int   n;
        logic got;
        e.is_err  = x_err;
        e.chk_dat = x_chk;
        e.dat     = x_dat;
        e.lat     = ws_of(d) + 1;
        sbq.push_back(e);
        exp_acc[d] = exp_acc[d] + 16'd1;
        if (x_err && exp_errc[d] != 8'hFF) exp_errc[d] = exp_errc[d] + 8'd1;
        @(negedge clk);
        adr[d] = a; dat_i[d] = wd; sel[d] = s; we[d] = w;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = ack[d] | err[d];
        end
        e = sbq.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'(e.lat));
        chk({tag, "_ack"}, {31'h0, ack[d]}, {31'h0, !e.is_err});
        chk({tag, "_err"}, {31'h0, err[d]}, {31'h0, e.is_err});
        if (e.chk_dat) chk({tag, "_dat"}, dat_o[d], e.dat);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        @(negedge clk);
        chk({tag, "_one_cycle"}, {31'h0, ack[d] | err[d]}, 32'h0);
        chk_counters(d, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        n_checks = 0;
        n_errors = 0;
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; adr[d] = '0; dat_i[d] = '0; sel[d] = '0;
            we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; inj[d] = 1'b0;
            exp_acc[d] = '0; exp_errc[d] = '0;
        end

        vt[0]  = mk(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0);
        vt[1]  = mk(1'b0, 32'h0000_1010, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);
        vt[2]  = mk(1'b1, 32'h0000_1020, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0);
        vt[3]  = mk(1'b1, 32'h0000_1020, 32'h1122_3344, 4'b0010, 1'b0, 1'b0, 32'h0);
        vt[4]  = mk(1'b0, 32'h0000_1020, 32'h0,         4'h1, 1'b0, 1'b1, 32'hFFFF_33FF);
        vt[5]  = mk(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0);
        vt[6]  = mk(1'b0, 32'h0000_1100, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0);
        vt[7]  = mk(1'b1, 32'h0000_1002, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 32'h0);
        vt[8]  = mk(1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b0, 1'b1, 32'hCAFE_F00D);
        vt[9]  = mk(1'b1, 32'h0000_1024, 32'h55AA_55AA, 4'hF, 1'b0, 1'b0, 32'h0);
        vt[10] = mk(1'b1, 32'h0000_1024, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0);
        vt[11] = mk(1'b0, 32'h0000_1024, 32'h0,         4'hF, 1'b0, 1'b1, 32'h55AA_55AA);
        vt[12] = mk(1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0);
        vt[13] = mk(1'b1, 32'h0000_10FC, 32'h0BAD_C0DE, 4'hF, 1'b0, 1'b0, 32'h0);
        vt[14] = mk(1'b0, 32'h0000_10FC, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0BAD_C0DE);
        vt[15] = mk(1'b1, 32'h0000_1030, 32'h0000_0000, 4'hF, 1'b0, 1'b0, 32'h0);
        vt[16] = mk(1'b1, 32'h0000_1030, 32'hAABB_CCDD, 4'b1001, 1'b0, 1'b0, 32'h0);
        vt[17] = mk(1'b0, 32'h0000_1030, 32'h0,         4'hF, 1'b0, 1'b1, 32'hAA00_00DD);
        vt[18] = mk(1'b0, 32'h0000_1011, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0);
        vt[19] = mk(1'b1, 32'hFFFF_FFFC, 32'h7777_7777, 4'hF, 1'b1, 1'b1, 32'h0);

        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_ack", {31'h0, ack[d]}, 32'h0);
            chk("reset_err", {31'h0, err[d]}, 32'h0);
            chk("reset_dat", dat_o[d], 32'h0);
            chk_counters(d, "reset");
        end
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            xfer(0, vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel,
                 vt[i].x_err, vt[i].x_chk, vt[i].x_dat, $sformatf("vec%0d", i));
        end

        // Strobe held through RESP and one cycle beyond: exactly one ack.
        exp_acc[0] = exp_acc[0] + 16'd1;
        @(negedge clk);
        adr[0] = 32'h0000_1010; we[0] = 1'b0; sel[0] = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
        @(negedge clk);
        chk("hold_ack", {31'h0, ack[0]}, 32'h1);
        chk("hold_dat", dat_o[0], 32'hDEAD_BEEF);
        @(negedge clk);
        chk("hold_no_second", {31'h0, ack[0] | err[0]}, 32'h0);
        chk("hold_dat_idle", dat_o[0], 32'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        chk_counters(0, "hold");

        // Wait states and abort on the two-wait-state instance.
        xfer(1, 1'b1, 32'h0000_1040, 32'h1357_9BDF, 4'hF, 1'b0, 1'b0, 32'h0, "ws2_wr");
        xfer(1, 1'b0, 32'h0000_1040, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1357_9BDF, "ws2_rd");
        xfer(1, 1'b0, 32'h0000_1100, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, "ws2_oow");
        @(negedge clk);
        adr[1] = 32'h0000_1040; dat_i[1] = 32'h0; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | ack[1] | err[1];
        end
        chk("abort_no_term", {31'h0, seen}, 32'h0);
        chk_counters(1, "abort");
        xfer(1, 1'b0, 32'h0000_1040, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1357_9BDF, "abort_mem");

        // Reset mid-WAIT on the three-wait-state instance.
        xfer(2, 1'b1, 32'h0000_1050, 32'hA1B2_C3D4, 4'hF, 1'b0, 1'b0, 32'h0, "rst_pre");
        @(negedge clk);
        adr[2] = 32'h0000_1050; dat_i[2] = 32'hFFFF_FFFF; sel[2] = 4'hF; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_waiting", {31'h0, ack[2] | err[2]}, 32'h0);
        rst[2] = 1'b1;
        #1;
        chk("rst_ack", {31'h0, ack[2]}, 32'h0);
        chk("rst_err", {31'h0, err[2]}, 32'h0);
        chk("rst_dat", dat_o[2], 32'h0);
        exp_acc[2]  = '0;
        exp_errc[2] = '0;
        chk_counters(2, "rst_mid");
        @(negedge clk);
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b0;
        xfer(2, 1'b0, 32'h0000_1050, 32'h0, 4'hF, 1'b0, 1'b1, 32'hA1B2_C3D4, "rst_mem");
        xfer(2, 1'b0, 32'h0000_1006, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, "ws3_misalign");

`ifdef WB_RESP_ERR_INJECT_EN
        xfer(0, 1'b1, 32'h0000_1060, 32'h1111_1111, 4'hF, 1'b0, 1'b0, 32'h0, "inj_pre");
        @(negedge clk);
        inj[0] = 1'b1;
        @(negedge clk);
        inj[0] = 1'b0;
        xfer(0, 1'b1, 32'h0000_1060, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b1, 32'h0, "inj_wr");
        xfer(0, 1'b0, 32'h0000_1060, 32'h0, 4'hF, 1'b0, 1'b1, 32'h1111_1111, "inj_after");
`endif

        // Drive the error counter into saturation and beyond.
        while (exp_errc[0] != 8'hFF) begin
            xfer(0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, "sat_fill");
        end
        xfer(0, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, "sat_hold");
        xfer(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFE_F00D, "sat_ok");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
